// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, instruction size and
// the instruction-fetch state encoding.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_e;

  // Clear the byte-offset bits so a target is instruction aligned.
  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & ~XLEN'(INSN_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, one buffered
// instruction handed to the decoder over a valid/ready pair.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   redirect_valid/pc   taken branch/jump target (highest priority)
//   imem_req/addr       request to instruction memory (word aligned)
//   imem_gnt            memory accepted the request
//   imem_rvalid/rdata   read response
//   inst_valid/ready    handshake to the decoder
//   inst_out/pc/next_pc buffered instruction, its pc and pc + 4
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_next_pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            capture;
  logic [XLEN-1:0] inst_q, ipc_q, npc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    capture = 1'b0;
    unique case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        if (imem_gnt) begin
          state_d = FS_WAIT;
          // Granted fetch is for the old pc; its data must be thrown away.
          drop_d  = redirect_valid;
        end
      end
      FS_WAIT: begin
        if (redirect_valid) begin
          drop_d = 1'b1;
        end else if (imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q) begin
            state_d = FS_REQ;
          end else begin
            capture = 1'b1;
            state_d = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (redirect_valid) begin
          state_d = FS_REQ;
        end else if (inst_ready) begin
          state_d = FS_REQ;
          pc_d    = pc_q + XLEN'(INSN_BYTES);
        end
      end
      default: state_d = FS_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // next_pc is registered so that it, too, reads zero in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q <= '0;
      ipc_q  <= '0;
      npc_q  <= '0;
    end else if (capture) begin
      inst_q <= imem_rdata;
      ipc_q  <= pc_q;
      npc_q  <= pc_q + XLEN'(INSN_BYTES);
    end
  end

  assign imem_req     = (state_q == FS_REQ);
  assign imem_addr    = pc_q;
  assign inst_valid   = (state_q == FS_HOLD);
  assign inst_out     = inst_q;
  assign inst_pc      = ipc_q;
  assign inst_next_pc = npc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, reset corner cases,
// then randomized traffic against a transaction-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_next_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .inst_next_pc(inst_next_pc)
  );

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        g;
    logic        rv;
    logic [31:0] rdat;
    logic        rdy;
    logic        er;
    logic [31:0] ea;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic rd, logic [31:0] rpc, logic g, logic rv,
    logic [31:0] rdat, logic rdy, logic er, logic [31:0] ea,
    logic ev, logic [31:0] ei, logic [31:0] ep);
    vec_t t;
    t.rd = rd; t.rpc = rpc; t.g = g; t.rv = rv;
    t.rdat = rdat; t.rdy = rdy; t.er = er; t.ea = ea;
    t.ev = ev; t.ei = ei; t.ep = ep;
    return t;
  endfunction

  function automatic logic [31:0] memword(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic rd, logic [31:0] rpc, logic g,
                       logic rv, logic [31:0] rdat, logic rdy);
    @(negedge clk);
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rdat;
    inst_ready     = rdy;
    #1;
  endtask

  task automatic expect_out(logic er, logic [31:0] ea, logic ev,
                            logic [31:0] ei, logic [31:0] ep);
    chk("imem_req", imem_req, er);
    if (er) chk("imem_addr", imem_addr, ea);
    chk("inst_valid", inst_valid, ev);
    if (ev) begin
      chk("inst_out", inst_out, ei);
      chk("inst_pc", inst_pc, ep);
      chk("inst_next_pc", inst_next_pc, ep + 32'd4);
    end
  endtask

  task automatic check_reset_outs();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_next", inst_next_pc, 0);
  endtask

  // Reset asserted at a falling edge, released just after a rising
  // edge so the following cycle is the first (IDLE) cycle.
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check_reset_outs();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Transaction-level reference model state.
  logic        m_boot, m_fetching, m_outstanding, m_discard, m_have;
  logic [31:0] m_pc, m_ipc;
  // Memory responder state.
  logic        mem_busy;
  int          mem_delay;
  logic [31:0] mem_addr, g_addr;

  localparam logic [31:0] I0 = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_0113;
  localparam logic [31:0] I3 = 32'h1234_5678;
  localparam logic [31:0] I4 = 32'hCAFE_F00D;
  localparam logic [31:0] I5 = 32'hDEAD_BEEF;
  localparam logic [31:0] I6 = 32'h0BAD_C0DE;
  localparam logic [31:0] JK = 32'hBADB_AD00;

  initial begin
    logic rd, g, rv, rdy;
    logic [31:0] tgt, rdat;

    // Directed table: each row is one cycle after reset release.
    tv.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, I0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, I0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,  0, 1, 4, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, I1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, I1, 4));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,  0, 1, 8, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, I2, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, I2, 8));
    tv.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, I2, 8));
    tv.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'hC, 0, 0, 0));
    tv.push_back(mk(1, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, JK, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'h100, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, I3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h200, 0, 0, 0, 1, 0, 0, 1, I3, 32'h100));
    tv.push_back(mk(0, 0, 0, 0, 0,  0, 1, 32'h200, 0, 0, 0));
    tv.push_back(mk(1, 32'h30A, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0));
    tv.push_back(mk(1, 32'h40C, 1, 0, 0, 0, 1, 32'h308, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, JK, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'h40C, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, I4, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, I4, 32'h40C));
    tv.push_back(mk(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 32'h410, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,  0, 1, 32'hFFFF_FFFC, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, I5, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, I5, 32'hFFFF_FFFC));
    tv.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0));

    do_reset();
    foreach (tv[i]) begin
      drive(tv[i].rd, tv[i].rpc, tv[i].g, tv[i].rv,
            tv[i].rdat, tv[i].rdy);
      expect_out(tv[i].er, tv[i].ea, tv[i].ev, tv[i].ei, tv[i].ep);
    end

    // Reset while a fetch is in flight, then a late response.
    drive(0, 0, 1, 0, 0, 0);
    expect_out(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check_reset_outs();
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 0, 1, JK, 0);
    expect_out(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, JK, 0);
    expect_out(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    expect_out(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, I6, 0);
    expect_out(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    expect_out(0, 0, 1, I6, 0);

    // Redirect in the IDLE cycle right after reset.
    do_reset();
    drive(1, 32'h55, 0, 0, 0, 0);
    expect_out(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    expect_out(1, 32'h54, 0, 0, 0);

    // Randomized traffic against the transaction model.
    do_reset();
    m_boot = 1; m_fetching = 0; m_outstanding = 0;
    m_discard = 0; m_have = 0; m_pc = 0; m_ipc = 0;
    mem_busy = 0; mem_delay = 0; mem_addr = 0; g_addr = 0;
    for (int c = 0; c < 4000; c++) begin
      rd  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 3) == 0) ?
            (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rv  = mem_busy && (mem_delay == 0);
      rdat = rv ? memword(mem_addr) : $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      g = imem_req && ($urandom_range(0, 3) != 0);
      g_addr = imem_addr;
      redirect_valid = rd;
      redirect_pc    = tgt;
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = rdat;
      inst_ready     = rdy;
      #1;
      expect_out(m_fetching, m_pc, m_have, memword(m_ipc), m_ipc);
      @(posedge clk);
      // Memory responder.
      if (rv) mem_busy = 0;
      if (g) begin
        mem_busy  = 1;
        mem_delay = $urandom_range(0, 3);
        mem_addr  = g_addr;
      end else if (mem_busy && mem_delay > 0) begin
        mem_delay--;
      end
      // Reference model: what the fetcher is doing at the transaction level.
      if (m_boot) begin
        m_boot = 0;
        m_fetching = 1;
      end else if (m_fetching) begin
        if (g) begin
          m_fetching = 0;
          m_outstanding = 1;
          m_discard = rd;
        end
      end else if (m_outstanding) begin
        if (rd) begin
          m_discard = 1;
        end else if (rv) begin
          m_outstanding = 0;
          if (m_discard) begin
            m_discard = 0;
            m_fetching = 1;
          end else begin
            m_have = 1;
            m_ipc = m_pc;
          end
        end
      end else if (m_have) begin
        if (rd || rdy) begin
          m_have = 0;
          m_fetching = 1;
          if (!rd) m_pc = m_pc + 32'd4;
        end
      end
      if (rd) m_pc = {tgt[31:2], 2'b00};
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/jump taken; load redirect_pc this cycle.
REQ-006 redirect_pc  input  32  redirect target address.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address, word aligned.
REQ-009 imem_gnt  input  1  memory accepted request this cycle.
REQ-010 imem_rvalid  input  1  read data valid; never asserted earlier than the cycle after the matching gnt.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 inst_valid  output  1  inst_out/inst_pc/inst_next_pc valid for the decoder.
REQ-013 inst_ready  input  1  decoder consumes the instruction.
REQ-014 inst_out  output  32  buffered instruction.
REQ-015 inst_pc  output  32  address of inst_out.
REQ-016 inst_next_pc  output  32  inst_pc + 4, mod 2^32.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-018 IDLE SHALL move to REQ unconditionally on the next cycle.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc_q; on imem_gnt, go to WAIT; otherwise stay in REQ.
REQ-020 In WAIT, on imem_rvalid, capture imem_rdata and pc_q into the output buffer and go to HOLD.
REQ-021 In HOLD, inst_valid SHALL be 1; on inst_ready, pc_q becomes pc_q+4 (wrapping at 2^32) and the FSM goes to REQ.
REQ-022 inst_valid SHALL be 0 in all states other than HOLD, and the outputs SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-023 Redirect SHALL have priority over every other event and load pc_q with {redirect_pc[31:2], 2'b00}.
REQ-024 Redirect in REQ without gnt: stay in REQ; imem_addr shows the new pc from the next cycle (address change while ungranted is legal).
REQ-025 Redirect in REQ with gnt in the same cycle: go to WAIT with drop_q=1.
REQ-026 Redirect in WAIT: set drop_q=1 and stay in WAIT, including when rvalid arrives that cycle; that response is discarded.
REQ-027 In WAIT with drop_q=1, imem_rvalid SHALL discard the data, clear drop_q and go to REQ, with no inst_valid pulse.
REQ-028 Redirect in HOLD: inst_valid drops next cycle and the FSM goes to REQ; a simultaneous inst_ready is ignored (the instruction is squashed).
REQ-029 Redirect in IDLE: go to REQ with the redirect pc.
REQ-030 The steady-state rate SHALL be one instruction per 3 cycles with gnt immediate, rvalid one cycle later and ready=1.

Reset
REQ-031 While reset is high, the state SHALL be IDLE, pc_q=RESET_PC, drop_q=0, and imem_req, inst_valid, inst_out, inst_pc and inst_next_pc SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; a late rvalid arriving in IDLE or REQ SHALL be ignored.
REQ-033 imem_req SHALL first assert in the second cycle after reset deassertion.

Structure
REQ-034 The package cpu_pkg SHALL hold the fetch-state enum, XLEN=32 and INSN_BYTES=4.
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 Reset release, gnt always 1, rvalid one cycle later, ready=1 -> imem_addr sequence 0x0, 0x4, 0x8, with inst_valid every 3rd cycle and inst_next_pc = inst_pc + 4.
REQ-037 gnt withheld for 5 cycles -> imem_req and imem_addr=0x0 held stable for 5 cycles, then a single fetch.
REQ-038 In HOLD with ready=0 for 4 cycles -> inst_out stable and no new imem_req; ready=1 -> next address 0x4.
REQ-039 Redirect to 0x103 while in WAIT -> the pending rvalid data is dropped with no inst_valid, and the next imem_addr is 0x100.
REQ-040 Redirect and inst_ready in the same HOLD cycle, target 0x200 -> no advance to pc+4, and the next imem_addr is 0x200.
REQ-041 Reset pulse while in WAIT, followed by a late rvalid -> ignored; fetch restarts at RESET_PC.
